hit_score_tracker: RTL and testbench

- Scoring stage of the reaction game, directly downstream of the debouncer and the 3-bit light position counter, and upstream of the 7-segment decoder.
- Converts the debounced button level and the current light position into scored hits and counted misses.
- Keeps a two-digit BCD score and runs a small PLAY/OVER game state machine.
- Replaces the bare AND-gate-plus-counter scoring path: one press yields at most one event, score digits feed the decoder directly.

---
 rtl/hit_score_tracker_pkg.sv | 20 ++
 rtl/hit_score_tracker_bcd_counter_2digit.sv | 42 ++++
 rtl/hit_score_tracker.sv | 136 +++++++++++++
 tb/tb_hit_score_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_score_tracker_pkg.sv
// Shared definitions for the reaction-game scoring stage.
// Holds the game state encoding, BCD digit width and default hit position.
// Also provides a BCD-to-binary helper for threshold compares.
package hit_score_tracker_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam int         BCD_W       = 4;
  localparam logic [2:0] DEF_HIT_POS = 3'd7;

  // Two BCD digits to a binary value in 0..99
  function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                            input logic [BCD_W-1:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/hit_score_tracker_bcd_counter_2digit.sv
// Two-digit BCD up-counter, saturating at 99.
// Latency: count visible one clk after the increment is sampled.
// Synchronous clear has priority over increment; no backpressure.
module bcd_counter_2digit
  import hit_score_tracker_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [BCD_W-1:0] o_ones,
  output logic [BCD_W-1:0] o_tens
);

  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] r_tens;
  logic             w_at_max;

  assign w_at_max = (r_tens == 4'd9) && (r_ones == 4'd9);

  // Clear, or step the BCD pair with ones->tens carry, holding at 99
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_clr) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_inc && !w_at_max) begin
      if (r_ones == 4'd9) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_ones = r_ones;
  assign o_tens = r_tens;

endmodule

// File: rtl/hit_score_tracker.sv
// Scores button presses against the light position; runs the PLAY/OVER game.
// Latency: events sampled at one edge show on the registered outputs after it.
// No backpressure: every press/expiry is resolved in the cycle it is seen.
module hit_score_tracker
  import hit_score_tracker_pkg::*;
#(
  parameter logic [2:0] HIT_POS    = DEF_HIT_POS,
  parameter int         WIN_SCORE  = 10,
  parameter int         MAX_MISSES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pos,
  input  logic             btn_level,
  output logic [BCD_W-1:0] score_ones,
  output logic [BCD_W-1:0] score_tens,
  output logic [1:0]       misses,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             game_over,
  output logic             win
);

  state_t     r_state;
  logic       r_btn_d;
  logic [2:0] r_pos_d;
  logic       r_armed;
  logic [1:0] r_misses;
  logic       r_hit_pulse;
  logic       r_miss_pulse;
  logic       r_win;

  logic       w_play;
  logic       w_press;
  logic       w_at_hit;
  logic       w_pos_chg;
  logic       w_enter;
  logic       w_leave;
  logic       w_armed_now;
  logic       w_hit;
  logic       w_miss;
  logic       w_restart;
  logic [6:0] w_score_bin;
  logic [1:0] w_misses_nxt;
  logic       w_win_now;
  logic       w_lose_now;
  logic [BCD_W-1:0] w_ones;
  logic [BCD_W-1:0] w_tens;

  assign w_play      = (r_state == ST_PLAY);
  assign w_press     = btn_level & ~r_btn_d;
  assign w_at_hit    = (pos == HIT_POS);
  assign w_pos_chg   = (pos != r_pos_d);
  assign w_enter     = w_pos_chg & w_at_hit;
  assign w_leave     = w_pos_chg & (r_pos_d == HIT_POS);
  // Entering the window arms it in the same cycle, so press-on-entry scores
  assign w_armed_now = r_armed | w_enter;

  // Hit and miss are mutually exclusive: a miss by expiry implies pos left HIT_POS
  assign w_hit     = w_play & w_press & w_at_hit & w_armed_now;
  assign w_miss    = w_play & ((w_press & ~w_at_hit) | (w_leave & r_armed));
  assign w_restart = ~w_play & w_press;

  assign w_score_bin  = bcd_to_bin(w_tens, w_ones);
  assign w_misses_nxt = (r_misses == 2'(MAX_MISSES)) ? r_misses : r_misses + 2'd1;
  assign w_win_now    = w_hit && ((w_score_bin + 7'd1) == 7'(WIN_SCORE));
  assign w_lose_now   = w_miss && (w_misses_nxt == 2'(MAX_MISSES));

  // Previous-cycle copies of the button and position for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_d <= 1'b0;
      r_pos_d <= 3'd0;
    end else begin
      r_btn_d <= btn_level;
      r_pos_d <= pos;
    end
  end

  // Game FSM with registered pulses, miss count, window arm and win flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_PLAY;
      r_armed      <= 1'b0;
      r_misses     <= 2'd0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      case (r_state)
        ST_PLAY: begin
          if (w_hit)        r_armed <= 1'b0;
          else if (w_enter) r_armed <= 1'b1;
          else if (w_leave) r_armed <= 1'b0;
          if (w_miss) r_misses <= w_misses_nxt;
          if (w_win_now) begin
            r_state <= ST_OVER;
            r_win   <= 1'b1;
          end else if (w_lose_now) begin
            r_state <= ST_OVER;
            r_win   <= 1'b0;
          end
        end
        ST_OVER: begin
          r_armed <= 1'b0;
          if (w_press) begin
            r_state  <= ST_PLAY;
            r_misses <= 2'd0;
            r_win    <= 1'b0;
          end
        end
        default: r_state <= ST_PLAY;
      endcase
    end
  end

  bcd_counter_2digit u_score (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_inc   (w_hit),
    .i_clr   (w_restart),
    .o_ones  (w_ones),
    .o_tens  (w_tens)
  );

  assign score_ones = w_ones;
  assign score_tens = w_tens;
  assign misses     = r_misses;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign game_over  = (r_state == ST_OVER);
  assign win        = r_win;

endmodule

// File: tb/tb_hit_score_tracker.sv
// Scenario bench for hit_score_tracker with a per-cycle expectation queue.
// Each cycle's stimulus and expected outputs are queued, then replayed and compared.
// Output vector layout: {hit, miss, game_over, win, tens, ones, misses}.
module tb_hit_score_tracker;

  logic       clk;
  logic       reset;
  logic [2:0] pos;
  logic       btn_level;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;
  logic       win;

  int errors = 0;
  int checks = 0;

  logic [13:0] sb[$];
  logic [3:0]  stim[$];

  hit_score_tracker #(
    .HIT_POS    (3'd7),
    .WIN_SCORE  (10),
    .MAX_MISSES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pos        (pos),
    .btn_level  (btn_level),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .misses     (misses),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over),
    .win        (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] ev(input logic h, input logic m, input logic g,
                                     input logic w, input int sc, input int mi);
    return {h, m, g, w, 4'(sc / 10), 4'(sc % 10), 2'(mi)};
  endfunction

  function automatic logic [13:0] outv();
    return {hit_pulse, miss_pulse, game_over, win, score_tens, score_ones, misses};
  endfunction

  task automatic plan(input logic [2:0] p, input logic b, input logic [13:0] e);
    stim.push_back({p, b});
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [2:0] p, input logic b);
    pos = p;
    btn_level = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pos = 3'd0;
    btn_level = 1'b0;
    #2;
    checks++;
    if (outv() !== ev(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", outv(), ev(0, 0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_hit();
    logic [13:0] e;
    logic [3:0]  st;
    int n = 0;
    for (int i = 0; i < 8; i++) plan(3'(i), 1'b0, ev(0, 0, 0, 0, 0, 0));
    plan(3'd7, 1'b1, ev(1, 0, 0, 0, 1, 0));   // armed window, press -> hit
    plan(3'd7, 1'b1, ev(0, 0, 0, 0, 1, 0));   // held: no second press
    plan(3'd7, 1'b0, ev(0, 0, 0, 0, 1, 0));
    plan(3'd7, 1'b1, ev(0, 0, 0, 0, 1, 0));   // window used: ignored
    plan(3'd0, 1'b0, ev(0, 0, 0, 0, 1, 0));   // leave disarmed: no miss
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL hit step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
  endtask

  task automatic test_miss();
    logic [13:0] e;
    logic [3:0]  st;
    int n = 0;
    plan(3'd3, 1'b1, ev(0, 1, 0, 0, 1, 1));   // press off-target
    plan(3'd3, 1'b0, ev(0, 0, 0, 0, 1, 1));
    plan(3'd7, 1'b0, ev(0, 0, 0, 0, 1, 1));   // arm
    plan(3'd0, 1'b0, ev(0, 1, 0, 0, 1, 2));   // expire unhit
    plan(3'd2, 1'b1, ev(0, 1, 1, 0, 1, 3));   // third miss -> loss
    plan(3'd2, 1'b0, ev(0, 0, 1, 0, 1, 3));
    plan(3'd7, 1'b0, ev(0, 0, 1, 0, 1, 3));   // frozen in OVER
    plan(3'd7, 1'b1, ev(0, 0, 0, 0, 0, 0));   // restart, not scored
    plan(3'd0, 1'b0, ev(0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL miss step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
  endtask

  task automatic test_win();
    logic [13:0] e;
    logic [3:0]  st;
    int n = 0;
    for (int k = 1; k <= 10; k++) begin
      plan(3'd7, 1'b0, ev(0, 0, 0, 0, k - 1, 0));
      plan(3'd7, 1'b1, ev(1, 0, k == 10, k == 10, k, 0));
      plan(3'd0, 1'b0, ev(0, 0, k == 10, k == 10, k, 0));
    end
    plan(3'd0, 1'b1, ev(0, 0, 0, 0, 0, 0));   // restart from win
    plan(3'd0, 1'b0, ev(0, 0, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL win step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
  endtask

  task automatic test_same_cycle();
    logic [13:0] e;
    logic [3:0]  st;
    int n = 0;
    plan(3'd7, 1'b1, ev(1, 0, 0, 0, 1, 0));   // press on entry -> hit
    plan(3'd0, 1'b0, ev(0, 0, 0, 0, 1, 0));
    plan(3'd7, 1'b0, ev(0, 0, 0, 0, 1, 0));   // arm
    plan(3'd0, 1'b1, ev(0, 1, 0, 0, 1, 1));   // press + expiry -> one miss
    plan(3'd0, 1'b0, ev(0, 0, 0, 0, 1, 1));
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL same_cycle step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    logic [3:0]  st;
    int n = 0;
    for (int s = 1; s < 5; s++) begin
      plan(3'd7, 1'b0, ev(0, 0, 0, 0, s, 1));
      plan(3'd7, 1'b1, ev(1, 0, 0, 0, s + 1, 1));
      plan(3'd0, 1'b0, ev(0, 0, 0, 0, s + 1, 1));
    end
    plan(3'd3, 1'b1, ev(0, 1, 0, 0, 5, 2));
    plan(3'd3, 1'b0, ev(0, 0, 0, 0, 5, 2));
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL reset_mid_pre step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outv() !== ev(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", outv(), ev(0, 0, 0, 0, 0, 0));
    end
    pos = 3'd3;
    btn_level = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (outv() !== ev(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_held got=%h exp=%h", outv(), ev(0, 0, 0, 0, 0, 0));
    end
    reset = 1'b1;
    plan(3'd3, 1'b1, ev(0, 1, 0, 0, 0, 1));   // held at release -> press, miss
    plan(3'd3, 1'b1, ev(0, 0, 0, 0, 0, 1));
    n = 0;
    while (sb.size() > 0) begin
      st = stim.pop_front();
      cyc(st[3:1], st[0]);
      e = sb.pop_front();
      checks++;
      if (outv() !== e) begin
        errors++;
        $display("FAIL reset_mid_post step%0d got=%h exp=%h", n, outv(), e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_win();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
